// File: rtl/fetch_unit_if.sv
// Handshake and ROM bus between the fetch unit, its instruction ROM
// and the control unit that consumes fetched instructions.
interface fetch_unit_if;
    logic [8:0]  address;
    logic [15:0] instr_in;
    logic        z_flag;
    logic [15:0] ir;
    logic [5:0]  opcode;
    logic [9:0]  operand;
    logic        ir_valid;
    logic        ir_ack;
    logic        halted;
    logic        err;
    logic [15:0] retired;

    modport master (
        output address, ir, opcode, operand,
        output ir_valid, halted, err, retired,
        input  instr_in, z_flag, ir_ack
    );

    modport slave (
        input  address, ir, opcode, operand,
        input  ir_valid, halted, err, retired,
        output instr_in, z_flag, ir_ack
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: ISSUE/LOAD/VALID/HALT sequencer with
// conditional jumps, range checking and a saturating retire counter.
module fetch_unit #(
    parameter int unsigned INST_COUNT = 200,
    parameter bit          NOP_HALTS  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam logic [5:0] OP_NOP    = 6'd46;
    localparam logic [5:0] OP_JUMPNZ = 6'd47;
    localparam logic [5:0] OP_JUMPZ  = 6'd52;

    typedef enum logic [1:0] {
        ISSUE,
        LOAD,
        VALID,
        HALT
    } state_t;

    state_t      state;
    logic [8:0]  pc;
    logic [15:0] ir;
    logic [15:0] retired;
    logic        ir_valid;
    logic        halted;
    logic        err;

    logic [5:0]  op;
    logic        take_jump;
    logic [8:0]  next_pc;
    logic        out_of_range;
    logic        nop_halt;

    assign op = ir[15:10];

    always_comb begin
        take_jump    = 1'b0;
        next_pc      = pc + 9'd1;
        out_of_range = 1'b0;
        nop_halt     = 1'b0;
        unique case (1'b1)
            op == OP_JUMPZ:  take_jump = bus.z_flag;
            op == OP_JUMPNZ: take_jump = !bus.z_flag;
            default:         take_jump = 1'b0;
        endcase
        // operand[9] is deliberately dropped: targets are 9-bit
        if (take_jump)
            next_pc = ir[8:0];
        out_of_range = 32'(next_pc) > INST_COUNT;
        nop_halt     = NOP_HALTS && (op == OP_NOP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ISSUE;
            pc       <= 9'd0;
            ir       <= 16'd0;
            retired  <= 16'd0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            unique case (state)
                ISSUE: begin
                    state <= LOAD;
                end
                LOAD: begin
                    ir       <= bus.instr_in;
                    ir_valid <= 1'b1;
                    state    <= VALID;
                end
                VALID: begin
                    if (bus.ir_ack) begin
                        ir_valid <= 1'b0;
                        pc       <= next_pc;
                        if (retired != 16'hFFFF)
                            retired <= retired + 16'd1;
                        // range error wins over a halting NOP
                        if (out_of_range) begin
                            err    <= 1'b1;
                            halted <= 1'b1;
                            state  <= HALT;
                        end else if (nop_halt) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= ISSUE;
                end
            endcase
        end
    end

    assign bus.address  = pc;
    assign bus.ir       = ir;
    assign bus.opcode   = ir[15:10];
    assign bus.operand  = ir[9:0];
    assign bus.ir_valid = ir_valid;
    assign bus.halted   = halted;
    assign bus.err      = err;
    assign bus.retired  = retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing/jump/halt/error scenarios and
// randomized programs checked by an instruction-level scoreboard.
module tb_fetch_unit;

    typedef struct {
        bit          halt;
        bit          err;
        logic [8:0]  addr;
        logic [15:0] ir;
        logic [15:0] ret;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    fetch_unit #(.INST_COUNT(3)) u_small (
        .clk(clk),
        .rst(rst2),
        .bus(bus2.master)
    );

    logic [15:0] rom [512];

    always @(posedge clk) begin
        bus.instr_in  <= rom[bus.address];
        bus2.instr_in <= rom[bus2.address];
    end

    int checks = 0;
    int failures = 0;

    rec_t q[$];
    int   mpc;
    logic [15:0] mret;
    bit   mhalt;
    int   icount;
    bit   mon_en = 0;
    bit   seen_halt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill_default();
        for (int i = 0; i < 512; i++)
            rom[i] = {6'd1, 10'd0};
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.ir_ack = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.ir_valid && n < 12) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.ir_valid)
            chk("valid_timeout", bus.ir_valid, 1);
    endtask

    task automatic step(input bit z);
        wait_valid();
        bus.z_flag = z;
        bus.ir_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ir_ack = 1'b0;
    endtask

    // Instruction-level model: executes one acknowledged instruction.
    task automatic model_ack(input bit z);
        logic [15:0] ins;
        int op;
        int nxt;
        ins = rom[mpc];
        op  = int'(ins[15:10]);
        if ((op == 52 && z) || (op == 47 && !z))
            nxt = int'(ins[8:0]);
        else
            nxt = (mpc + 1) % 512;
        if (mret != 16'hFFFF)
            mret = mret + 16'd1;
        mpc = nxt;
        icount++;
        if (nxt > 200) begin
            q.push_back('{1'b1, 1'b1, 9'(nxt), 16'h0, mret});
            mhalt = 1;
        end else if (op == 46) begin
            q.push_back('{1'b1, 1'b0, 9'(nxt), 16'h0, mret});
            mhalt = 1;
        end else begin
            q.push_back('{1'b0, 1'b0, 9'(nxt), rom[nxt], mret});
        end
    endtask

    task automatic monitor();
        rec_t cur;
        rec_t hr;
        bit pv;
        bit ph;
        pv = 0;
        ph = 0;
        cur = '{1'b0, 1'b0, 9'd0, 16'd0, 16'd0};
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                pv = 0;
                ph = 0;
            end else begin
                if (bus.ir_valid && !pv) begin
                    chk("sb_queue_has_instr", 32'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        cur = q.pop_front();
                        chk("sb_kind_instr", 32'(cur.halt), 0);
                        chk("sb_address", bus.address, cur.addr);
                        chk("sb_ir", bus.ir, cur.ir);
                        chk("sb_opcode", bus.opcode, cur.ir[15:10]);
                        chk("sb_operand", bus.operand, cur.ir[9:0]);
                        chk("sb_retired", bus.retired, cur.ret);
                    end
                end else if (bus.ir_valid) begin
                    chk("sb_ir_stable", bus.ir, cur.ir);
                end
                if (bus.halted && !ph) begin
                    chk("sb_queue_has_halt", 32'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        hr = q.pop_front();
                        chk("sb_kind_halt", 32'(hr.halt), 1);
                        chk("sb_halt_address", bus.address, hr.addr);
                        chk("sb_halt_err", bus.err, hr.err);
                        chk("sb_halt_retired", bus.retired, hr.ret);
                        chk("sb_halt_valid", bus.ir_valid, 0);
                    end
                    seen_halt = 1;
                end
                pv = bus.ir_valid;
                ph = bus.halted;
            end
        end
    endtask

    function automatic logic [15:0] rand_instr();
        int r;
        logic [5:0] op;
        r = $urandom_range(0, 19);
        if (r < 4)
            return {6'd52, 1'($urandom), 9'($urandom_range(0, 230))};
        if (r < 8)
            return {6'd47, 1'($urandom), 9'($urandom_range(0, 230))};
        if (r == 8)
            return {6'd46, 10'($urandom)};
        op = 6'($urandom_range(0, 63));
        if (op == 6'd46 || op == 6'd47 || op == 6'd52)
            op = 6'd1;
        return {op, 10'($urandom)};
    endfunction

    int jop [5]  = '{52, 52, 47, 47, 52};
    int jopd [5] = '{179, 179, 63, 63, 512 + 100};
    int jz [5]   = '{1, 0, 0, 1, 1};
    int jexp [5] = '{179, 6, 63, 6, 100};
    logic [15:0] exp_ir [3] = '{16'h0800, 16'h0C00, 16'h1000};

    initial begin
        bus.ir_ack  = 1'b0;
        bus.z_flag  = 1'b0;
        bus2.ir_ack = 1'b1;
        bus2.z_flag = 1'b0;
        fill_default();
        fork
            monitor();
            begin
                #2000000;
                $display("FAIL watchdog: got timeout expected finish");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_address", bus.address, 0);
        chk("rst_ir", bus.ir, 0);
        chk("rst_valid", bus.ir_valid, 0);
        chk("rst_halted", bus.halted, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_retired", bus.retired, 0);

        // Small instance: out-of-range halt, then reset mid-LOAD
        rst2 = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        chk("range_err", bus2.err, 1);
        chk("range_halted", bus2.halted, 1);
        chk("range_address", bus2.address, 4);
        chk("range_retired", bus2.retired, 4);
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midload_retired_pre", bus2.retired, 1);
        chk("midload_address_pre", bus2.address, 1);
        #1;
        rst2 = 1'b1;
        #1;
        chk("midload_address", bus2.address, 0);
        chk("midload_ir", bus2.ir, 0);
        chk("midload_valid", bus2.ir_valid, 0);
        chk("midload_halted", bus2.halted, 0);
        chk("midload_err", bus2.err, 0);
        chk("midload_retired", bus2.retired, 0);

        // Throughput and timing with ack tied high
        rom[0] = 16'h0800;
        rom[1] = 16'h0C00;
        rom[2] = 16'h1000;
        do_reset();
        bus.ir_ack = 1'b1;
        chk("t0_address", bus.address, 0);
        chk("t0_valid", bus.ir_valid, 0);
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_valid", e), bus.ir_valid, 32'(e % 3 == 2));
            chk($sformatf("t%0d_address", e), bus.address, e / 3);
            if (e % 3 == 2)
                chk($sformatf("t%0d_ir", e), bus.ir, exp_ir[e / 3]);
        end
        bus.ir_ack = 1'b0;
        fill_default();

        // Ack withheld for 10 clocks
        do_reset();
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_ir", bus.ir, 16'h0400);
            chk("hold_valid", bus.ir_valid, 1);
            chk("hold_retired", bus.retired, 0);
        end
        bus.ir_ack = 1'b1;
        @(posedge clk);
        #1;
        bus.ir_ack = 1'b0;
        chk("hold_ack_retired", bus.retired, 1);
        chk("hold_ack_valid", bus.ir_valid, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_single_inc", bus.retired, 1);

        // Conditional jumps from pc 5
        for (int i = 0; i < 5; i++) begin
            rom[5] = {6'(jop[i]), 10'(jopd[i])};
            do_reset();
            repeat (5) step(1'b0);
            step(1'(jz[i]));
            chk($sformatf("jump%0d_address", i), bus.address, jexp[i]);
            chk($sformatf("jump%0d_err", i), bus.err, 0);
        end
        fill_default();

        // NOP halt at 185; acks in HALT are ignored
        rom[0] = {6'd52, 10'd185};
        rom[185] = {6'd46, 10'd0};
        do_reset();
        step(1'b1);
        step(1'b0);
        chk("nop_halted", bus.halted, 1);
        chk("nop_valid", bus.ir_valid, 0);
        chk("nop_address", bus.address, 186);
        chk("nop_err", bus.err, 0);
        for (int i = 0; i < 3; i++) begin
            bus.ir_ack = 1'b1;
            @(posedge clk);
            #1;
            bus.ir_ack = 1'b0;
            @(posedge clk);
            #1;
            chk("nop_hold_address", bus.address, 186);
            chk("nop_hold_retired", bus.retired, 2);
            chk("nop_hold_ir", bus.ir, 16'hB800);
            chk("nop_hold_halted", bus.halted, 1);
        end

        // Randomized programs against the instruction-level model
        for (int round = 0; round < 25; round++) begin
            bit done;
            int hold_cnt;
            rst = 1'b1;
            bus.ir_ack = 1'b0;
            for (int i = 0; i < 512; i++)
                rom[i] = rand_instr();
            q.delete();
            mpc = 0;
            mret = 16'd0;
            mhalt = 0;
            icount = 0;
            seen_halt = 0;
            q.push_back('{1'b0, 1'b0, 9'd0, rom[0], 16'd0});
            mon_en = 1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            done = 0;
            hold_cnt = 0;
            for (int cyc = 0; cyc < 1500 && !done; cyc++) begin
                @(posedge clk);
                #1;
                if (seen_halt) begin
                    chk("rand_halt_address", bus.address, 9'(mpc));
                    chk("rand_halt_retired", bus.retired, mret);
                    chk("rand_halt_valid", bus.ir_valid, 0);
                    hold_cnt++;
                end
                bus.z_flag = 1'($urandom);
                if (bus.ir_valid)
                    bus.ir_ack = (icount < 40) && ($urandom_range(0, 2) != 0);
                else
                    bus.ir_ack = 1'($urandom);
                if (bus.ir_valid && bus.ir_ack)
                    model_ack(bus.z_flag);
                done = (mhalt && seen_halt && hold_cnt >= 4) ||
                       (!mhalt && icount >= 40 && q.size() == 0 &&
                        bus.ir_valid);
            end
            chk("rand_round_done", 32'(done), 1);
            chk("rand_queue_drained", q.size(), 0);
            bus.ir_ack = 1'b0;
            @(negedge clk);
            mon_en = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter INST_COUNT, default 200, meaning highest valid instruction address; larger pc values are out of range.
REQ-002 Parameter NOP_HALTS, default 1, meaning a NOP (opcode 46) stops fetching when 1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 address  output  9  instruction ROM address, driven directly from the pc register.
REQ-006 instr_in  input  16  ROM data; valid one clock after address is sampled.
REQ-007 z_flag  input  1  accumulator-zero flag from the datapath, sampled at ack.
REQ-008 ir  output  16  instruction register.
REQ-009 opcode  output  6  ir[15:10].
REQ-010 operand  output  10  ir[9:0].
REQ-011 ir_valid  output  1  ir holds a fetched instruction that has not been acknowledged.
REQ-012 ir_ack  input  1  control unit has consumed ir.
REQ-013 halted  output  1  fetching has stopped.
REQ-014 err  output  1  pc went out of range.
REQ-015 retired  output  16  count of acknowledged instructions; saturates at 16'hFFFF.

Function
REQ-016 States SHALL be ISSUE, LOAD, VALID and HALT.
REQ-017 ISSUE: address = pc; the ROM samples it at this edge; next state LOAD.
REQ-018 LOAD: ir <= instr_in; next state VALID.
REQ-019 VALID: ir_valid = 1 and ir is held stable; the state is held until ir_ack = 1 is sampled.
REQ-020 ir_valid SHALL be high only in VALID, as a registered output.
REQ-021 ir_ack outside VALID SHALL be ignored and SHALL NOT change retired.
REQ-022 At the acked edge, next pc SHALL be:
- operand[8:0] if opcode = 52 (JUMPZ) and z_flag = 1;
- operand[8:0] if opcode = 47 (JUMPNZ) and z_flag = 0;
- otherwise pc + 1, 9-bit.
REQ-023 At the acked edge, retired SHALL increment by 1, saturating.
REQ-024 At the acked edge, the next state SHALL be HALT if opcode = 46 and NOP_HALTS = 1; otherwise ISSUE.
REQ-025 If the next pc > INST_COUNT, the next state SHALL be HALT with err = 1, and pc SHALL keep the offending value. This check has priority over the NOP rule.
REQ-026 When pc = 511, pc + 1 SHALL wrap to 0; 0 is in range, so err is not raised by the wrap alone.
REQ-027 A jump with operand[9] = 1 SHALL use operand[8:0] only.
REQ-028 HALT: halted = 1 and ir_valid = 0; ir, pc, retired and err are held. Exit from HALT is by rst only.
REQ-029 Throughput SHALL be 3 clocks per instruction with ir_ack tied high.
REQ-030 opcode and operand SHALL be continuous slices of ir.

Reset
REQ-031 While rst = 1, the block SHALL hold pc = 0, ir = 0, ir_valid = 0, halted = 0, err = 0, retired = 0 and state = ISSUE.
REQ-032 Reset asserted in any state, including mid-LOAD or VALID, SHALL take effect immediately and asynchronously and discard the in-flight instruction.
REQ-033 Reset release SHALL be synchronised by the surrounding system.
REQ-034 The first edge after release SHALL be an ISSUE of address 0.

Verification
REQ-035 ROM[0..2] = CLAC, MVACMAR, LDAC; ir_ack tied 1 -> ir_valid pulses at edges 2, 5 and 8 after release; ir = 16'h0800, 16'h0C00, 16'h1000; address = 0, 1, 2, 3.
REQ-036 ROM[5] = {52, 10'd179} -> with z_flag = 1 at ack, next address = 179; with z_flag = 0, next address = 6.
REQ-037 ROM[5] = {47, 10'd63} -> with z_flag = 0, address = 63; with z_flag = 1, address = 6.
REQ-038 ir_ack held 0 for 10 clocks in VALID -> ir and ir_valid stable, retired unchanged; ack then causes exactly one increment.
REQ-039 ROM[185] = NOP reached -> halted = 1, ir_valid = 0, address = 186, err = 0; ir_ack pulses in HALT change nothing.
REQ-040 INST_COUNT = 3 with no jumps -> after 4 acks, err = 1, halted = 1, address = 4; rst asserted mid-LOAD -> all outputs at reset values in the same cycle.
